// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and widths for the UART TX arbiter
package uart_pkg;

  localparam int GID_W = 3;
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// rtl/uart_rr_arb.sv - combinational round-robin picker, search starts after last_grant
module uart_rr_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GID_W-1:0]   last_grant,
  output logic [GID_W-1:0]   winner,
  output logic               found
);

  always_comb begin : pick
    int idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      // constant-index inner loop keeps the select width-clean
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          found  = 1'b1;
          winner = GID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin share of one UART TX channel
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter bit         PREFIX_EN = 1'b0,
  parameter logic [7:0] ID_BASE   = 8'hF0,
  parameter int         MAX_PKT   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 pkt_abort
);

  localparam bit               WDOG_EN = (MAX_PKT != 0);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT);

  arb_state_t       state, state_nxt;
  logic [GID_W-1:0] grant_nxt;
  logic [CNT_W-1:0] byte_cnt, cnt_nxt;
  logic             abort_nxt;

  logic [GID_W-1:0] arb_winner;
  logic             arb_found;

  logic [7:0]       sel_data;
  logic             sel_valid;
  logic             sel_last;

  uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req        (req_valid),
    .last_grant (grant_id),
    .winner     (arb_winner),
    .found      (arb_found)
  );

  always_comb begin
    sel_data  = 8'h00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        sel_data  = req_data[i*8 +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      grant_id  <= GID_W'(NUM_REQ - 1);
      byte_cnt  <= '0;
      pkt_abort <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_id  <= grant_nxt;
      byte_cnt  <= cnt_nxt;
      pkt_abort <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    cnt_nxt   = byte_cnt;
    abort_nxt = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    req_ready = '0;
    case (state)
      ST_IDLE: begin
        if (arb_found) begin
          grant_nxt = arb_winner;
          cnt_nxt   = '0;
          state_nxt = PREFIX_EN ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        tx_data  = ID_BASE + {5'b00000, grant_id};
        tx_valid = 1'b1;
        if (tx_ready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_data  = sel_data;
        tx_valid = sel_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_id == GID_W'(i)) req_ready[i] = tx_ready;
        end
        if (sel_valid && tx_ready) begin
          cnt_nxt = byte_cnt + 1'b1;
          // last wins over the watchdog when both land on the same byte
          if (sel_last) begin
            state_nxt = ST_IDLE;
          end else if (WDOG_EN && (cnt_nxt == MAX_CNT)) begin
            state_nxt = ST_IDLE;
            abort_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int WD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [N*8-1:0] a_req_data, b_req_data;
  logic [N-1:0]   a_req_valid, a_req_last, a_req_ready;
  logic [N-1:0]   b_req_valid, b_req_last, b_req_ready;
  logic [7:0]     a_tx_data, b_tx_data;
  logic           a_tx_valid, a_tx_ready, b_tx_valid, b_tx_ready;
  logic [2:0]     a_grant_id, b_grant_id;
  logic           a_busy, a_pkt_abort, b_busy, b_pkt_abort;

  uart_tx_arbiter #(.NUM_REQ(N), .PREFIX_EN(1'b0), .ID_BASE(8'hF0), .MAX_PKT(WD)) dut_a (
    .clk(clk), .rst(rst_n), .req_data(a_req_data), .req_valid(a_req_valid),
    .req_last(a_req_last), .req_ready(a_req_ready), .tx_data(a_tx_data),
    .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .grant_id(a_grant_id),
    .busy(a_busy), .pkt_abort(a_pkt_abort));

  uart_tx_arbiter #(.NUM_REQ(N), .PREFIX_EN(1'b1), .ID_BASE(8'hF0), .MAX_PKT(256)) dut_b (
    .clk(clk), .rst(rst_n), .req_data(b_req_data), .req_valid(b_req_valid),
    .req_last(b_req_last), .req_ready(b_req_ready), .tx_data(b_tx_data),
    .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .grant_id(b_grant_id),
    .busy(b_busy), .pkt_abort(b_pkt_abort));

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [7:0] d;
    logic       ab;
  } exp_t;

  logic [8:0] rq [N][$];
  exp_t       expq [$];
  logic       exp_abort_next;
  int         abort_cnt;
  int         rdy3_viol;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic [3:0] er;
    logic [2:0] eg;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clear_inputs();
    a_req_data = '0; a_req_valid = '0; a_req_last = '0; a_tx_ready = 1'b0;
    b_req_data = '0; b_req_valid = '0; b_req_last = '0; b_tx_ready = 1'b0;
    for (int i = 0; i < N; i++) rq[i].delete();
    expq.delete();
    exp_abort_next = 1'b0;
    abort_cnt = 0;
    rdy3_viol = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Packet-level model: round-robin over non-empty streams, packet ends at last or WD bytes.
  task automatic build_model(input int last_g);
    logic [8:0] cq [N][$];
    logic [8:0] e;
    int g, n;
    bit stalled;
    for (int i = 0; i < N; i++) cq[i] = rq[i];
    expq.delete();
    stalled = 1'b0;
    while (!stalled) begin
      g = -1;
      for (int k = 1; k <= N; k++)
        if (g < 0 && cq[(last_g + k) % N].size() > 0) g = (last_g + k) % N;
      if (g < 0) break;
      n = 0;
      stalled = 1'b1;
      while (cq[g].size() > 0) begin
        e = cq[g].pop_front();
        n++;
        if (e[8]) begin
          expq.push_back('{g: 3'(g), d: e[7:0], ab: 1'b0});
          stalled = 1'b0;
          break;
        end else if (n == WD) begin
          expq.push_back('{g: 3'(g), d: e[7:0], ab: 1'b1});
          stalled = 1'b0;
          break;
        end else begin
          expq.push_back('{g: 3'(g), d: e[7:0], ab: 1'b0});
        end
      end
      last_g = g;
    end
  endtask

  task automatic cycle_q(input bit rdy);
    exp_t e;
    @(negedge clk);
    a_tx_ready = rdy;
    for (int i = 0; i < N; i++) begin
      a_req_valid[i]      = (rq[i].size() > 0);
      a_req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
      a_req_last[i]       = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
    end
    #1;
    check("pkt_abort", {31'd0, a_pkt_abort}, {31'd0, exp_abort_next});
    if (a_pkt_abort) abort_cnt++;
    exp_abort_next = 1'b0;
    if (a_busy && a_grant_id == 3'd0 && a_req_ready[3]) rdy3_viol++;
    if (a_tx_valid && a_tx_ready) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_byte actual=%0h required=none at %0t", a_tx_data, $time);
      end else begin
        e = expq.pop_front();
        check("tx_byte", {24'd0, a_tx_data}, {24'd0, e.d});
        check("tx_grant", {29'd0, a_grant_id}, {29'd0, e.g});
        exp_abort_next = e.ab;
      end
    end
    for (int i = 0; i < N; i++)
      if (a_req_ready[i] && a_req_valid[i]) void'(rq[i].pop_front());
  endtask

  task automatic run_q(input string name, input int budget, input bit random_rdy, input bit toggle);
    int cyc;
    cyc = 0;
    while (expq.size() > 0 && cyc < budget) begin
      cycle_q(toggle ? cyc[0] : (random_rdy ? ($urandom_range(0, 3) != 0) : 1'b1));
      cyc++;
    end
    if (expq.size() > 0) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=%0d required=0 bytes left", name, expq.size());
    end
    cycle_q(1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int len;
    //            v  d      l  rdy ev ed     eb er       eg
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 3'd3};
    tbl[1] = '{1'b1, 8'h41, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 4'b0100, 3'd2};
    tbl[2] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h42, 1'b1, 4'b0100, 3'd2};
    tbl[3] = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b1, 8'h43, 1'b1, 4'b0100, 3'd2};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 4'b0000, 3'd2};

    rst_n = 1'b0;
    clear_inputs();
    #12;
    check("rst_tx_valid", {31'd0, a_tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, a_tx_data}, 32'd0);
    check("rst_req_ready", {28'd0, a_req_ready}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_abort", {31'd0, a_pkt_abort}, 32'd0);
    check("rst_grant", {29'd0, a_grant_id}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;

    // single requester 2, three bytes, no header
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_tx_ready = tbl[k].rdy;
      a_req_valid = {1'b0, tbl[k].v, 2'b00};
      a_req_last  = {1'b0, tbl[k].l, 2'b00};
      a_req_data  = {8'h00, tbl[k].d, 16'h0000};
      #1;
      check($sformatf("vec%0d_tx_valid", k), {31'd0, a_tx_valid}, {31'd0, tbl[k].ev});
      check($sformatf("vec%0d_tx_data", k), {24'd0, a_tx_data}, {24'd0, tbl[k].ed});
      check($sformatf("vec%0d_busy", k), {31'd0, a_busy}, {31'd0, tbl[k].eb});
      check($sformatf("vec%0d_req_ready", k), {28'd0, a_req_ready}, {28'd0, tbl[k].er});
      check($sformatf("vec%0d_grant", k), {29'd0, a_grant_id}, {29'd0, tbl[k].eg});
    end

    // header insertion on the prefixed instance
    do_reset();
    @(negedge clk);
    b_tx_ready = 1'b1; b_req_valid = 4'b0010; b_req_last = 4'b0010; b_req_data = 32'h0000_5500;
    #1;
    check("hdr_idle_valid", {31'd0, b_tx_valid}, 32'd0);
    @(negedge clk); #1;
    check("hdr_valid", {31'd0, b_tx_valid}, 32'd1);
    check("hdr_byte", {24'd0, b_tx_data}, 32'hF1);
    check("hdr_req_ready", {28'd0, b_req_ready}, 32'd0);
    @(negedge clk); #1;
    check("hdr_data_byte", {24'd0, b_tx_data}, 32'h55);
    check("hdr_data_ready", {28'd0, b_req_ready}, 32'b0010);
    @(negedge clk);
    b_req_valid = '0; b_req_last = '0;
    #1;
    check("hdr_done_busy", {31'd0, b_busy}, 32'd0);

    // round-robin fairness with one idle bubble between 1-byte packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h10 * (i + 1) + r)});
    build_model(N - 1);
    for (int k = 0; k < 10; k++) begin
      cycle_q(1'b1);
      check($sformatf("rr_bubble%0d", k), {31'd0, a_tx_valid}, {31'd0, 1'(k % 2)});
    end
    run_q("rr", 50, 1'b0, 1'b0);

    // atomicity under toggling backpressure
    do_reset();
    for (int j = 0; j < 4; j++) rq[0].push_back({(j == 3), 8'(8'hA0 + j)});
    rq[3].push_back({1'b1, 8'hB0});
    build_model(N - 1);
    run_q("atomic", 60, 1'b0, 1'b1);
    check("atomic_rdy3_held", rdy3_viol, 32'd0);

    // watchdog abort, then normal end when last coincides with the limit
    do_reset();
    for (int j = 0; j < 6; j++) rq[1].push_back({1'b0, 8'(8'hC0 + j)});
    rq[2].push_back({1'b1, 8'hD0});
    build_model(N - 1);
    run_q("wdog", 60, 1'b0, 1'b0);
    check("wdog_abort_count", abort_cnt, 32'd1);
    do_reset();
    for (int j = 0; j < 4; j++) rq[1].push_back({(j == 3), 8'(8'hE0 + j)});
    build_model(N - 1);
    run_q("wdog_last", 60, 1'b0, 1'b0);
    check("wdog_last_no_abort", abort_cnt, 32'd0);

    // asynchronous reset during byte 2 of 5
    do_reset();
    for (int j = 0; j < 5; j++) rq[0].push_back({(j == 4), 8'(8'h60 + j)});
    build_model(N - 1);
    cycle_q(1'b1);
    cycle_q(1'b1);
    cycle_q(1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", {31'd0, a_tx_valid}, 32'd0);
    check("midrst_req_ready", {28'd0, a_req_ready}, 32'd0);
    check("midrst_busy", {31'd0, a_busy}, 32'd0);
    check("midrst_abort", {31'd0, a_pkt_abort}, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    rq[3].push_back({1'b1, 8'h73});
    rq[0].push_back({1'b1, 8'h70});
    build_model(N - 1);
    run_q("midrst_after", 40, 1'b0, 1'b0);

    // randomized streams against the packet-level model
    for (int round = 0; round < 6; round++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        len = $urandom_range(0, 9);
        for (int j = 0; j < len; j++)
          rq[i].push_back({(j == len - 1) || ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255))});
      end
      build_model(N - 1);
      run_q($sformatf("rand%0d", round), 2000, 1'b1, 1'b0);
      for (int i = 0; i < N; i++)
        check($sformatf("rand%0d_drained%0d", round, i), rq[i].size(), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter channel between `NUM_REQ` byte-stream requesters (CPU, debug monitor, DMA, etc.). Packets are granted round-robin and kept atomic: once a requester is granted, it keeps the transmitter until its `last` byte is accepted. An optional per-packet source-ID header byte can be inserted. A packet-length watchdog stops a stuck requester from holding the transmitter. The block sits between the requesters and the TX data/valid/ready port of the UART core.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `PREFIX_EN`, 0: when 1, emit header byte `ID_BASE + grant index` before the first byte of each packet.
- `ID_BASE`, 8'hF0: base value of the header byte.
- `MAX_PKT`, 256: maximum data bytes per grant, excluding the header; 0 disables the watchdog; range 0..65535.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `req_data` in `NUM_REQ*8`: byte lane i is `[8i+7:8i]`.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_last` in `NUM_REQ`: marks the final byte of a packet; qualified by valid.
- `req_ready` out `NUM_REQ`: per-requester byte accepted.
- `tx_data` out 8: byte to the UART transmitter.
- `tx_valid` out 1: byte valid to the UART transmitter.
- `tx_ready` in 1: UART transmitter can accept a byte.
- `grant_id` out 3: index of the current or most recent grant.
- `busy` out 1: high in HDR or DATA.
- `pkt_abort` out 1: one-cycle pulse when the watchdog forces a release.

## Operation
- State machine:
  - IDLE: if any `req_valid` is high, pick the winner round-robin, register `grant_id`, reset the byte counter, then go to HDR if `PREFIX_EN`, else DATA. Otherwise stay in IDLE.
  - HDR: `tx_data` = `ID_BASE + grant_id` (modulo 256) and `tx_valid` = 1. On `tx_ready`, go to DATA. The granted requester's `req_ready` stays 0.
  - DATA: pass-through of the granted lane. `tx_data` = `req_data[g]`, `tx_valid` = `req_valid[g]`, `req_ready[g]` = `tx_ready`. All other `req_ready` bits are 0.
    - Each accepted byte (valid & ready) increments the byte counter.
    - An accepted byte with `req_last[g]` set moves the FSM to IDLE.
    - An accepted byte that brings the count to `MAX_PKT` (if `MAX_PKT` ≠ 0) without `last` moves the FSM to IDLE and pulses `pkt_abort`.
    - If `last` and the watchdog limit coincide on the same byte, treat it as a normal end: no abort.
- Round-robin: the search starts at `grant_id + 1` and wraps modulo `NUM_REQ`. Because reset sets `grant_id` to `NUM_REQ-1`, requester 0 has first priority after reset.
- `req_valid` dropping in DATA stalls the transfer; the grant is held and there is no timeout on idle cycles.
- `req_valid` rising on other requesters during DATA has no effect until IDLE.
- A non-granted requester's `req_last` is ignored.
- Outputs gated by state: `tx_valid` = 0 and all `req_ready` = 0 in IDLE.

## Timing
- Reset values:
  - state IDLE, byte counter 0, `grant_id` = `NUM_REQ-1`.
  - `tx_valid` 0, `tx_data` 8'h00, `req_ready` all 0.
  - `busy` 0, `pkt_abort` 0.
- Arbitration latency: `req_valid` seen high in IDLE at edge n gives `tx_valid` high in cycle n+1 (HDR or DATA).
- DATA path is combinational, so zero added latency. Sustained throughput is one byte per cycle when `tx_ready` is held high.
- Packet turnaround: exactly one IDLE bubble cycle after the final byte before the next header or data byte.
- A 1-byte packet with `last` high takes one DATA cycle if `tx_ready` is high.
- `pkt_abort` is high in the cycle after the aborting byte is accepted, i.e. the first IDLE cycle. `busy` follows the registered state.
- Reset asserted mid-packet takes effect immediately (asynchronous). The partially sent packet is dropped with no abort pulse. Reset release is synchronised by the top level.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE/HDR/DATA).
  - Grant-ID width constant (3).
  - Byte-counter width constant (16).
- Sub-module `uart_rr_arb`: combinational round-robin priority picker. Inputs: request vector and last grant. Outputs: winner index and a `found` flag.
- Top holds the FSM, byte counter and output muxing.

## Test plan
- Single requester: requester 2 sends 3 bytes 8'h41/42/43 with `last` on 8'h43, `tx_ready` held 1, `PREFIX_EN`=0 -> `tx_data` 41,42,43 in consecutive cycles starting 1 cycle after valid, then `busy` falls.
- Header insertion: `PREFIX_EN`=1, requester 1 sends 1 byte 8'h55 -> UART receives 8'hF1 then 8'h55.
- Round-robin fairness: all 4 requesters continuously valid, 1-byte packets -> grant order 0,1,2,3,0, with one IDLE cycle between packets.
- Atomicity under backpressure: requester 0 sends a 4-byte packet, `tx_ready` toggles every cycle, requester 3 is valid throughout -> all 4 bytes of requester 0 are sent in order before any byte of requester 3; `req_ready[3]` stays 0.
- Watchdog: `MAX_PKT`=4, requester 1 streams 6 bytes with no `last` -> 4 bytes sent, `pkt_abort` pulses once, the next grant goes to the next valid requester; the same packet with `last` on byte 4 gives no abort.
- Reset mid-packet: assert `rst` low during byte 2 of 5 -> `tx_valid` and `req_ready` go to 0 immediately; after release the first grant goes to requester 0.
